// File: rtl/apb_req_scheduler.sv
// Two-requester round-robin front end for an APB master: grants one requester,
// runs a single SETUP/ACCESS transfer and returns a registered ACK/RDATA/ERR.
module apb_req_scheduler #(
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned SLOT_LSB = 24
) (
  input  logic        PCLK,
  input  logic        PRESETN,
  input  logic [1:0]  REQ,
  input  logic [1:0]  WR,
  input  logic [31:0] ADDR0,
  input  logic [31:0] ADDR1,
  input  logic [31:0] WDATA0,
  input  logic [31:0] WDATA1,
  output logic [1:0]  ACK,
  output logic [31:0] RDATA,
  output logic        ERR,
  output logic [15:0] PSEL,
  output logic [31:0] PADDR,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam int unsigned      CNT_W     = 10;
  // Timeout fires on the wait cycle that brings the count up to TIMEOUT.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic             last_q, last_d;    // requester granted most recently
  logic             owner_q, owner_d;  // requester owning the transfer in flight
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [1:0]       ack_q, ack_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [15:0]      psel_q, psel_d;
  logic [31:0]      paddr_q, paddr_d;
  logic             penable_q, penable_d;
  logic             pwrite_q, pwrite_d;
  logic [31:0]      pwdata_q, pwdata_d;

  logic             winner;
  logic [31:0]      win_addr;
  logic [31:0]      win_wdata;
  logic             win_wr;
  logic             done;
  logic             done_err;
  logic [31:0]      done_rdata;

  // Round-robin pick: on a tie the requester not granted last time wins.
  always_comb begin
    winner    = (REQ == 2'b11) ? ~last_q : REQ[1];
    win_addr  = winner ? ADDR1  : ADDR0;
    win_wdata = winner ? WDATA1 : WDATA0;
    win_wr    = WR[winner];
  end

  // A ready slave always wins over the timeout, even on the limit cycle.
  always_comb begin
    done       = 1'b0;
    done_err   = 1'b0;
    done_rdata = '0;
    if (state_q == ACCESS) begin
      if (PREADY) begin
        done       = 1'b1;
        done_err   = PSLVERR;
        done_rdata = pwrite_q ? 32'd0 : PRDATA;
      end else if (wait_q == WAIT_LAST) begin
        done     = 1'b1;
        done_err = 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned and no latch is inferred.
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    wait_d    = wait_q;
    ack_d     = 2'b00;
    rdata_d   = '0;
    err_d     = 1'b0;
    psel_d    = psel_q;
    paddr_d   = paddr_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;

    case (state_q)
      IDLE: begin
        // No grant in the ACK cycle: the acknowledged requester still shows REQ high.
        if ((REQ != 2'b00) && (ack_q == 2'b00)) begin
          state_d   = SETUP;
          last_d    = winner;
          owner_d   = winner;
          psel_d    = 16'd1 << win_addr[SLOT_LSB +: 4];
          paddr_d   = win_addr;
          pwrite_d  = win_wr;
          pwdata_d  = win_wr ? win_wdata : 32'd0;
          penable_d = 1'b0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        wait_d    = '0;
      end
      ACCESS: begin
        if (done) begin
          state_d   = IDLE;
          ack_d     = 2'b01 << owner_q;
          rdata_d   = done_rdata;
          err_d     = done_err;
          psel_d    = '0;
          paddr_d   = '0;
          penable_d = 1'b0;
          pwrite_d  = 1'b0;
          pwdata_d  = '0;
          wait_d    = '0;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!PRESETN) begin
      // NOTE: the reset is synchronous, so it only takes effect at a clock edge; a transfer in flight is dropped without ACK.
      state_q   <= IDLE;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      wait_q    <= '0;
      ack_q     <= 2'b00;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      psel_q    <= '0;
      paddr_q   <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      wait_q    <= wait_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      psel_q    <= psel_d;
      paddr_q   <= paddr_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
    end
  end

  assign ACK     = ack_q;
  assign RDATA   = rdata_q;
  assign ERR     = err_q;
  assign PSEL    = psel_q;
  assign PADDR   = paddr_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PWDATA  = pwdata_q;

endmodule

// File: tb/tb_apb_req_scheduler.sv
// Bench for apb_req_scheduler: a transaction-level model checked every cycle,
// plus directed transfers with hand-computed latencies and data.
module tb_apb_req_scheduler;

  localparam int TB_TIMEOUT = 4;

  logic        PCLK    = 1'b0;
  logic        PRESETN = 1'b0;
  logic [1:0]  REQ     = 2'b00;
  logic [1:0]  WR      = 2'b00;
  logic [31:0] ADDR0   = '0;
  logic [31:0] ADDR1   = '0;
  logic [31:0] WDATA0  = '0;
  logic [31:0] WDATA1  = '0;
  logic [1:0]  ACK;
  logic [31:0] RDATA;
  logic        ERR;
  logic [15:0] PSEL;
  logic [31:0] PADDR;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA  = '0;
  logic        PREADY  = 1'b0;
  logic        PSLVERR = 1'b0;

  apb_req_scheduler #(.TIMEOUT(TB_TIMEOUT), .SLOT_LSB(24)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .REQ(REQ), .WR(WR),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .ACK(ACK), .RDATA(RDATA), .ERR(ERR), .PSEL(PSEL), .PADDR(PADDR),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave: inserts slave_waits wait cycles in each ACCESS phase.
  int          slave_waits  = 0;
  int          slave_cnt    = 0;
  logic [31:0] slave_prdata = '0;
  logic        slave_err    = 1'b0;

  always @(negedge PCLK) begin
    if (PENABLE === 1'b1) begin
      PREADY = (slave_cnt >= slave_waits);
      slave_cnt++;
    end else begin
      PREADY    = 1'b0;
      slave_cnt = 0;
    end
    PRDATA  = slave_prdata;
    PSLVERR = slave_err;
  end

  // Transaction model: a transfer is "busy" from grant until its completion,
  // spending one setup cycle then access cycles until ready or timeout.
  logic [1:0]  e_ack;
  logic [31:0] e_rdata;
  logic        e_err;
  logic [15:0] e_psel;
  logic        e_penable;
  logic [31:0] e_paddr;
  logic        e_pwrite;
  logic [31:0] e_pwdata;
  bit          m_busy;
  bit          m_in_setup;
  bit          m_was_ack;
  logic        m_who;
  logic        m_tie_winner;
  bit          m_wr;
  int          m_waits;
  logic [31:0] m_addr;

  always @(posedge PCLK) begin
    if (!PRESETN) begin
      m_busy       = 1'b0;
      m_tie_winner = 1'b0;
      e_ack        = 2'b00;
      e_rdata      = '0;
      e_err        = 1'b0;
      e_psel       = '0;
      e_penable    = 1'b0;
      e_paddr      = '0;
      e_pwrite     = 1'b0;
      e_pwdata     = '0;
    end else begin
      m_was_ack = (e_ack != 2'b00);
      e_ack     = 2'b00;
      e_rdata   = '0;
      e_err     = 1'b0;
      if (!m_busy) begin
        if (!m_was_ack && REQ != 2'b00) begin
          m_who        = (REQ == 2'b11) ? m_tie_winner : (REQ == 2'b10);
          m_tie_winner = ~m_who;
          m_busy       = 1'b1;
          m_in_setup   = 1'b1;
          m_waits      = 0;
          m_addr       = m_who ? ADDR1 : ADDR0;
          m_wr         = WR[m_who];
          e_psel       = 16'h1 << m_addr[27:24];
          e_penable    = 1'b0;
          e_paddr      = m_addr;
          e_pwrite     = m_wr;
          e_pwdata     = m_wr ? (m_who ? WDATA1 : WDATA0) : 32'd0;
        end
      end else if (m_in_setup) begin
        m_in_setup = 1'b0;
        e_penable  = 1'b1;
      end else if (PREADY || (m_waits + 1 == TB_TIMEOUT)) begin
        e_ack     = m_who ? 2'b10 : 2'b01;
        e_err     = PREADY ? PSLVERR : 1'b1;
        e_rdata   = (PREADY && !m_wr) ? PRDATA : 32'd0;
        e_psel    = '0;
        e_penable = 1'b0;
        m_busy    = 1'b0;
      end else begin
        m_waits++;
      end
    end
  end

  always @(negedge PCLK) begin
    check("ack",     32'(ACK),     32'(e_ack));
    check("rdata",   RDATA,        e_rdata);
    check("err",     32'(ERR),     32'(e_err));
    check("psel",    32'(PSEL),    32'(e_psel));
    check("penable", 32'(PENABLE), 32'(e_penable));
    if (e_psel != 16'h0) begin
      check("paddr",  PADDR,        e_paddr);
      check("pwrite", 32'(PWRITE),  32'(e_pwrite));
      check("pwdata", PWDATA,       e_pwdata);
    end
  end

  // One requester transfer; counts cycles from the grant cycle to ACK inclusive.
  task automatic do_txn(input logic who, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int waits, input logic [31:0] prdata,
                        input logic slverr, input logic [15:0] exp_psel, input int exp_lat,
                        input logic [31:0] exp_rdata, input logic exp_err);
    int cyc;
    slave_waits  = waits;
    slave_prdata = prdata;
    slave_err    = slverr;
    if (who) begin ADDR1 = addr; WDATA1 = wdata; end
    else     begin ADDR0 = addr; WDATA0 = wdata; end
    WR[who]  = wr;
    REQ[who] = 1'b1;
    cyc = 1;
    do begin
      @(negedge PCLK);
      cyc++;
      if (cyc == 2) begin
        check("setup_psel",    32'(PSEL),    32'(exp_psel));
        check("setup_penable", 32'(PENABLE), 32'd0);
        check("setup_paddr",   PADDR,        addr);
        check("setup_pwdata",  PWDATA,       wr ? wdata : 32'd0);
      end
      if (cyc == 3) begin
        check("access_psel",    32'(PSEL),    32'(exp_psel));
        check("access_penable", 32'(PENABLE), 32'd1);
      end
    end while (ACK[who] !== 1'b1 && cyc < 40);
    check("latency",   32'(cyc), 32'(exp_lat));
    check("ack_rdata", RDATA,    exp_rdata);
    check("ack_err",   32'(ERR), 32'(exp_err));
    REQ[who] = 1'b0;
    @(negedge PCLK);
  endtask

  logic [1:0] order [3];
  int         ack_cyc [3];
  int         n_acks;
  int         cyc;

  initial begin
    repeat (2) @(negedge PCLK);
    check("rst_ack",     32'(ACK),     32'd0);
    check("rst_psel",    32'(PSEL),    32'd0);
    check("rst_penable", 32'(PENABLE), 32'd0);
    check("rst_pwdata",  PWDATA,       32'd0);
    PRESETN = 1'b1;
    @(negedge PCLK);

    //     who  wr    addr          wdata         wt   prdata        err   psel      lat rdata         err
    do_txn(1'b0, 1'b1, 32'h0300_0010, 32'hA5A5_0001, 0,   32'h0,        1'b0, 16'h0008, 4, 32'h0,        1'b0);
    do_txn(1'b1, 1'b0, 32'h0A00_0100, 32'h0,         3,   32'hDEAD_BEEF, 1'b0, 16'h0400, 7, 32'hDEAD_BEEF, 1'b0);
    do_txn(1'b0, 1'b0, 32'h0100_0000, 32'h0,         100, 32'h1234_5678, 1'b0, 16'h0002, 7, 32'h0,        1'b1);
    do_txn(1'b1, 1'b1, 32'h0000_0040, 32'h0BAD_F00D, 0,   32'h0,        1'b0, 16'h0001, 4, 32'h0,        1'b0);
    do_txn(1'b0, 1'b1, 32'h0500_0000, 32'h0000_0011, 0,   32'h0,        1'b1, 16'h0020, 4, 32'h0,        1'b1);
    do_txn(1'b1, 1'b0, 32'h0F00_0008, 32'h0,         3,   32'h55AA_33CC, 1'b0, 16'h8000, 7, 32'h55AA_33CC, 1'b0);

    // Requester drops REQ right after the grant; the transfer still completes.
    ADDR0 = 32'h0400_0000; WR[0] = 1'b0;
    slave_waits = 0; slave_err = 1'b0; slave_prdata = 32'h0000_0077;
    REQ[0] = 1'b1;
    @(negedge PCLK);
    REQ[0] = 1'b0;
    cyc = 2;
    while (ACK[0] !== 1'b1 && cyc < 40) begin
      @(negedge PCLK);
      cyc++;
    end
    check("dropreq_latency", 32'(cyc), 32'd4);
    check("dropreq_rdata",   RDATA,    32'h0000_0077);
    @(negedge PCLK);

    // Fresh reset, then both request together; requester 0 keeps requesting.
    PRESETN = 1'b0;
    repeat (2) @(negedge PCLK);
    PRESETN = 1'b1;
    ADDR0 = 32'h0200_0000; ADDR1 = 32'h0300_0000; WR = 2'b00;
    order[0] = 2'b00; order[1] = 2'b00; order[2] = 2'b00;
    REQ = 2'b11;
    cyc = 1;
    n_acks = 0;
    while (n_acks < 3 && cyc < 60) begin
      @(negedge PCLK);
      cyc++;
      if (ACK != 2'b00) begin
        order[n_acks]   = ACK;
        ack_cyc[n_acks] = cyc;
        n_acks++;
        if (ACK == 2'b10) REQ[1] = 1'b0;
        if (n_acks == 3) REQ = 2'b00;
      end
    end
    check("arb_first",   32'(order[0]), 32'h1);
    check("arb_second",  32'(order[1]), 32'h2);
    check("arb_third",   32'(order[2]), 32'h1);
    check("arb_lat",     32'(ack_cyc[0]), 32'd4);
    check("arb_space_a", 32'(ack_cyc[1] - ack_cyc[0]), 32'd4);
    check("arb_space_b", 32'(ack_cyc[2] - ack_cyc[1]), 32'd4);
    @(negedge PCLK);

    // Reset in the middle of an ACCESS phase abandons the transfer.
    slave_waits = 100; ADDR1 = 32'h0600_0000; WR[1] = 1'b0;
    REQ[1] = 1'b1;
    cyc = 0;
    do begin
      @(negedge PCLK);
      cyc++;
    end while (PENABLE !== 1'b1 && cyc < 20);
    check("midrst_in_access", 32'(PENABLE), 32'd1);
    PRESETN = 1'b0;
    slave_waits = 0;
    @(negedge PCLK);
    check("midrst_psel",    32'(PSEL),    32'd0);
    check("midrst_penable", 32'(PENABLE), 32'd0);
    check("midrst_ack",     32'(ACK),     32'd0);
    PRESETN = 1'b1;
    cyc = 1;
    do begin
      @(negedge PCLK);
      cyc++;
    end while (ACK[1] !== 1'b1 && cyc < 40);
    check("regrant_latency", 32'(cyc), 32'd4);
    REQ = 2'b00;
    repeat (3) @(negedge PCLK);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/apb_req_scheduler.md
APB_REQ_SCHEDULER -- requirements
Module: apb_req_scheduler

Interface
REQ-001: The module SHALL have parameter TIMEOUT, default 255; it sets the maximum number of ACCESS cycles with PREADY low before forced termination (range 1-1023).
REQ-002: The module SHALL have parameter SLOT_LSB, default 24; it is the lowest address bit of the 4-bit slot field decoded into PSEL.
REQ-003: PCLK  in  1  single clock; all logic on rising edge.
REQ-004: PRESETN  in  1  reset, synchronous, active-low.
REQ-005: REQ  in  2  per-requester request, bit i = requester i; held high until ACK[i].
REQ-006: WR  in  2  per-requester direction, 1 = write; sampled with REQ.
REQ-007: ADDR0 / ADDR1  in  32 each  requester byte addresses.
REQ-008: WDATA0 / WDATA1  in  32 each  requester write data.
REQ-009: ACK  out  2  one-cycle completion pulse to the granted requester.
REQ-010: RDATA  out  32  read data, valid in the ACK cycle only.
REQ-011: ERR  out  1  error flag, valid in the ACK cycle only.
REQ-012: PSEL  out  16  one-hot APB slot select.
REQ-013: PADDR  out  32  APB address.
REQ-014: PENABLE  out  1  APB access phase.
REQ-015: PWRITE  out  1  APB direction.
REQ-016: PWDATA  out  32  APB write data.
REQ-017: PRDATA  in  32  APB read data.
REQ-018: PREADY  in  1  APB slave ready.
REQ-019: PSLVERR  in  1  APB slave error.

Function
REQ-020: The FSM SHALL have states IDLE, SETUP and ACCESS; reset state is IDLE.
REQ-021: In IDLE with any REQ bit high, it SHALL grant one requester, register its ADDR/WR/WDATA, and go to SETUP the next cycle.
REQ-022: Arbitration SHALL be round-robin on a 1-bit last-grant pointer: if both request, the one not last granted wins; a single requester wins regardless of the pointer; the pointer updates on grant.
REQ-023: In SETUP: PSEL[ADDR[SLOT_LSB+3:SLOT_LSB]] = 1, other PSEL bits 0, PENABLE = 0; next state ACCESS unconditionally.
REQ-024: In ACCESS: PENABLE = 1; PSEL/PADDR/PWRITE/PWDATA held stable from SETUP.
REQ-025: The ACCESS cycle with PREADY = 1 SHALL complete the transfer: next cycle ACK[grant] = 1, RDATA = PRDATA registered (0 for writes), ERR = PSLVERR registered, PSEL = 0, PENABLE = 0, state IDLE.
REQ-026: Minimum transfer latency SHALL be 4 cycles, grant-cycle to ACK inclusive, with zero wait states; a new grant SHALL NOT occur in the ACK cycle, so back-to-back transfers are 4 cycles apart.
REQ-027: A wait counter SHALL count ACCESS cycles with PREADY = 0; when it reaches TIMEOUT the transfer SHALL end as in REQ-025 but with ERR = 1 and RDATA = 0; the counter clears on every SETUP.
REQ-028: PREADY and the timeout reached in the same cycle SHALL be treated as a normal completion using PSLVERR.
REQ-029: A REQ deasserted before ACK is a protocol violation; the transfer in flight SHALL still complete and ACK SHALL still pulse.
REQ-030: PWDATA SHALL be 0 for reads; RDATA and ERR SHALL be 0 in all non-ACK cycles.
REQ-031: Outputs SHALL be registered; no combinational path from REQ, PRDATA, PREADY or PSLVERR to any output.

Reset
REQ-032: With PRESETN low at a PCLK edge, the next state SHALL be IDLE; ACK, RDATA, ERR, PSEL, PADDR, PENABLE, PWRITE, PWDATA SHALL be 0; the grant pointer SHALL select requester 0 as next winner; the wait counter SHALL be 0.
REQ-033: Reset asserted mid-transfer SHALL abandon it with no ACK generated, and APB signals SHALL be 0 in the cycle after the reset edge.

Verification
REQ-034: REQ=01, WR0=1, ADDR0=0x0300_0010, WDATA0=0xA5A5_0001, PREADY=1 -> PSEL=0x0008, PADDR=0x0300_0010, PWDATA=0xA5A5_0001 for 2 cycles, PENABLE high in the 2nd; ACK=01 with ERR=0 four cycles after grant.
REQ-035: REQ=11 simultaneously from reset, both reads -> requester 0 served first, then requester 1; REQ0 reasserted immediately -> requester 1 still served before requester 0's second transfer.
REQ-036: Read with PRDATA=0xDEAD_BEEF, PREADY low for 3 ACCESS cycles then high -> ACK after 7 cycles total, RDATA=0xDEAD_BEEF, ERR=0.
REQ-037: TIMEOUT=4, PREADY held 0 -> exactly 4 wait cycles then ACK with ERR=1, RDATA=0; the next transfer proceeds normally.
REQ-038: PSLVERR=1 with PREADY=1 on a write -> ACK with ERR=1; PREADY=1 in the same cycle the timeout is reached with PSLVERR=0 -> ERR=0.
REQ-039: PRESETN low during ACCESS -> no ACK; PSEL=0, PENABLE=0 the next cycle; the pending REQ is re-granted after reset release.
